// File: rtl/alu_result_stage_pkg.sv
// Shared opcode constants, buffer state encoding and counter limit for the
// ALU result stage.
package alu_result_stage_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOT  = 3'b000;
    localparam logic [OP_W-1:0] OP_AND  = 3'b001;
    localparam logic [OP_W-1:0] OP_OR   = 3'b010;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b011;
    localparam logic [OP_W-1:0] OP_PASS = 3'b100;

    // Number of flag bits carried next to the result: zero, neg, illegal.
    localparam int FLAG_W = 3;

    localparam logic [7:0] ILL_CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry valid/ready buffer. HEAD always drives the output side; TAIL only
// fills when a push arrives while HEAD is stalled. Both handshake outputs come
// straight from the state register.
module alu_skid_buf
    import alu_result_stage_pkg::*;
#(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_valid_i,
    output logic         push_ready_o,
    input  logic [W-1:0] push_data_i,
    output logic         pop_valid_o,
    input  logic         pop_ready_i,
    output logic [W-1:0] pop_data_o
);

    buf_state_e   state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         push, pop;

    assign push_ready_o = (state_q != BUF_TWO);
    assign pop_valid_o  = (state_q != BUF_EMPTY);
    assign pop_data_o   = head_q;

    assign push = push_valid_i & push_ready_o;
    assign pop  = pop_valid_o & pop_ready_i;

    // Next-state and entry updates for the EMPTY/ONE/TWO occupancy machine.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            BUF_EMPTY: begin
                if (push) begin
                    head_d  = push_data_i;
                    state_d = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (push && pop) begin
                    head_d = push_data_i;
                end else if (push) begin
                    tail_d  = push_data_i;
                    state_d = BUF_TWO;
                end else if (pop) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = BUF_ONE;
                end
            end
            default: begin
                state_d = BUF_EMPTY;
            end
        endcase
    end

    // State and entry registers; reset discards anything buffered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Result stage behind the ALU bitwise units: picks one unit output by opcode,
// derives zero/neg/illegal flags, buffers the tuple toward writeback and
// counts accepted reserved opcodes.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int size = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] op,
    input  logic [size-1:0] not_res,
    input  logic [size-1:0] and_res,
    input  logic [size-1:0] or_res,
    input  logic [size-1:0] xor_res,
    input  logic [size-1:0] a_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [size-1:0] out_result,
    output logic            out_zero,
    output logic            out_neg,
    output logic            out_illegal,
    output logic [7:0]      illegal_count
);

    localparam int PAY_W = size + FLAG_W;

    logic [size-1:0]  sel_result;
    logic             sel_illegal;
    logic             sel_zero;
    logic             sel_neg;
    logic [PAY_W-1:0] push_payload;
    logic [PAY_W-1:0] head_payload;
    logic             push;
    logic [7:0]       ill_cnt_q, ill_cnt_d;

    // Opcode mux; reserved opcodes yield a zero result flagged illegal.
    always_comb begin
        sel_result  = '0;
        sel_illegal = 1'b0;
        case (op)
            OP_NOT:  sel_result = not_res;
            OP_AND:  sel_result = and_res;
            OP_OR:   sel_result = or_res;
            OP_XOR:  sel_result = xor_res;
            OP_PASS: sel_result = a_in;
            default: sel_illegal = 1'b1;
        endcase
    end

    assign sel_zero     = (sel_result == '0);
    assign sel_neg      = sel_result[size-1];
    assign push_payload = {sel_result, sel_zero, sel_neg, sel_illegal};
    assign push         = in_valid & in_ready;

    alu_skid_buf #(
        .W (PAY_W)
    ) u_buf (
        .clk          (clk),
        .reset        (reset),
        .push_valid_i (in_valid),
        .push_ready_o (in_ready),
        .push_data_i  (push_payload),
        .pop_valid_o  (out_valid),
        .pop_ready_i  (out_ready),
        .pop_data_o   (head_payload)
    );

    assign out_result  = head_payload[PAY_W-1:FLAG_W];
    assign out_zero    = head_payload[2];
    assign out_neg     = head_payload[1];
    assign out_illegal = head_payload[0];

    // Saturating count of reserved opcodes that were actually accepted.
    always_comb begin
        ill_cnt_d = ill_cnt_q;
        if (push && sel_illegal && (ill_cnt_q != ILL_CNT_MAX)) begin
            ill_cnt_d = ill_cnt_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ill_cnt_q <= '0;
        end else begin
            ill_cnt_q <= ill_cnt_d;
        end
    end

    assign illegal_count = ill_cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: the driver pushes expected tuples on
// accept, a monitor pops and compares whenever the DUT hands off a result.
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] op = 3'b000;
    logic [7:0] not_res = 8'h00, and_res = 8'h00, or_res = 8'h00;
    logic [7:0] xor_res = 8'h00, a_in = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_result;
    logic       out_zero, out_neg, out_illegal;
    logic [7:0] illegal_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] exp_q[$];
    int          model_cnt = 0;
    int          n_out = 0;

    logic        prev_stall = 1'b0;
    logic [10:0] prev_tuple = '0;

    always #5 clk = ~clk;

    alu_result_stage #(.size(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .op            (op),
        .not_res       (not_res),
        .and_res       (and_res),
        .or_res        (or_res),
        .xor_res       (xor_res),
        .a_in          (a_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_zero      (out_zero),
        .out_neg       (out_neg),
        .out_illegal   (out_illegal),
        .illegal_count (illegal_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: tuple {result, zero, neg, illegal} from the opcode table.
    function automatic logic [10:0] model(input logic [2:0] o, input logic [7:0] n,
                                          input logic [7:0] a, input logic [7:0] r,
                                          input logic [7:0] x, input logic [7:0] p);
        logic [7:0] v;
        if (o > 3'd4) return {8'h00, 1'b1, 1'b0, 1'b1};
        v = (o == 3'd0) ? n : (o == 3'd1) ? a : (o == 3'd2) ? r : (o == 3'd3) ? x : p;
        return {v, (v == 8'h00), v[7], 1'b0};
    endfunction

    // Monitor: compare every handoff, stability while stalled, and the counter.
    always @(negedge clk) begin
        logic [10:0] cur;
        cur = {out_result, out_zero, out_neg, out_illegal};
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            chk("illegal_count", illegal_count, model_cnt[7:0]);
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_hold", cur, prev_tuple);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got 'h%0h, expected none", cur);
                end else begin
                    chk("out_tuple", cur, exp_q.pop_front());
                    n_out++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_tuple = cur;
        end
    end

    // One-cycle push attempt; records the expectation only if accepted.
    task automatic try_push(input logic [2:0] o, input logic [7:0] n, input logic [7:0] a,
                            input logic [7:0] r, input logic [7:0] x, input logic [7:0] p,
                            output bit acc);
        op = o; not_res = n; and_res = a; or_res = r; xor_res = x; a_in = p;
        in_valid = 1'b1;
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            exp_q.push_back(model(o, n, a, r, x, p));
            if (o > 3'd4 && model_cnt < 255) model_cnt++;
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        model_cnt = 0;
        reset = 1'b0;
    endtask

    task automatic drain();
        int t;
        out_ready = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_done", exp_q.size(), 0);
    endtask

    initial begin
        bit acc;
        int t;
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_result", out_result, 8'h00);
        chk("rst_flags", {out_zero, out_neg, out_illegal}, 3'b000);
        chk("rst_count", illegal_count, 8'h00);
        @(posedge clk);
        #1;

        // Basic ops and latency.
        out_ready = 1'b1;
        try_push(3'b000, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, acc);
        @(negedge clk);
        chk("lat_out_valid", out_valid, 1'b1);
        chk("not_tuple", {out_result, out_zero, out_neg, out_illegal}, {8'hF0, 3'b010});
        @(posedge clk);
        #1;
        try_push(3'b001, 8'hFF, 8'h00, 8'h55, 8'h12, 8'h34, acc);
        try_push(3'b100, 8'h00, 8'h01, 8'h02, 8'h03, 8'h7F, acc);
        drain();

        // Stall: two accepted, third refused, ordered drain.
        out_ready = 1'b0;
        try_push(3'b001, 8'h00, 8'h11, 8'h00, 8'h00, 8'h00, acc);
        chk("stall_acc1", acc, 1'b1);
        try_push(3'b010, 8'h00, 8'h00, 8'h22, 8'h00, 8'h00, acc);
        chk("stall_acc2", acc, 1'b1);
        try_push(3'b011, 8'h00, 8'h00, 8'h00, 8'h33, 8'h00, acc);
        chk("stall_acc3_refused", acc, 1'b0);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_head", out_result, 8'h11);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("after_pop_in_ready", in_ready, 1'b1);
        chk("after_pop_head", out_result, 8'h22);
        drain();

        // Back-to-back with out_ready high.
        for (int i = 0; i < 10; i++) begin
            try_push(3'b100, 8'h00, 8'h00, 8'h00, 8'h00, 8'(i * 17 + 3), acc);
            chk("b2b_accept", acc, 1'b1);
        end
        drain();

        // Reserved ops and saturation.
        do_reset();
        try_push(3'b101, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, acc);
        try_push(3'b110, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, acc);
        try_push(3'b111, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, acc);
        drain();
        chk("ill_count_3", illegal_count, 8'd3);
        for (int i = 0; i < 300; i++) begin
            try_push(3'(5 + (i % 3)), 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, acc);
        end
        drain();
        chk("ill_count_sat", illegal_count, 8'hFF);

        // Reset while full.
        out_ready = 1'b0;
        try_push(3'b000, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00, acc);
        try_push(3'b101, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, acc);
        chk("pre_rst_full", in_ready, 1'b0);
        out_ready = 1'b1;
        do_reset();
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_count", illegal_count, 8'h00);
        n_out = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("no_stale_outputs", n_out, 0);

        // Randomized traffic; rejected inputs are held until accepted.
        for (int i = 0; i < 400; i++) begin
            logic [2:0] o;
            logic [7:0] v[5];
            o = 3'($urandom_range(0, 7));
            for (int k = 0; k < 5; k++) v[k] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) v[$urandom_range(0, 4)] = 8'h00;
            if ($urandom_range(0, 4) == 0) begin
                out_ready = 1'($urandom);
                @(posedge clk);
                #1;
            end
            acc = 1'b0;
            t = 0;
            while (!acc && t < 50) begin
                out_ready = ($urandom_range(0, 2) != 0);
                try_push(o, v[0], v[1], v[2], v[3], v[4], acc);
                t++;
            end
            if (!acc) chk("rand_accept_timeout", acc, 1'b1);
        end
        drain();
        repeat (3) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
